// File: rtl/cache_line_bank.sv
`timescale 1ns/1ps
// Single-way L1 data bank: line-wide array, word read port, one-entry byte-masked store buffer, refill engine.
// Define CACHE_LINE_BANK_FWD_EN to merge buffered store bytes into same-line reads instead of stalling them.
module cache_line_bank #(
   parameter int unsigned INDEX_WIDTH = 7,
   parameter int unsigned LINE_WORDS  = 8,
   parameter int unsigned WORD_WIDTH  = 32,
   localparam int unsigned OFFSET_WIDTH = $clog2(LINE_WORDS),
   localparam int unsigned BEN_WIDTH    = WORD_WIDTH / 8,
   localparam int unsigned LINE_WIDTH   = LINE_WORDS * WORD_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [INDEX_WIDTH-1:0]  rd_index,
   input  logic [OFFSET_WIDTH-1:0] rd_offset,
   output logic                    rd_data_valid,
   output logic [WORD_WIDTH-1:0]   rd_data,
   output logic [LINE_WIDTH-1:0]   rd_line,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [INDEX_WIDTH-1:0]  st_index,
   input  logic [OFFSET_WIDTH-1:0] st_offset,
   input  logic [WORD_WIDTH-1:0]   st_data,
   input  logic [BEN_WIDTH-1:0]    st_ben,
   input  logic                    rf_start,
   input  logic [INDEX_WIDTH-1:0]  rf_index,
   input  logic                    rf_valid,
   output logic                    rf_ready,
   input  logic [WORD_WIDTH-1:0]   rf_data,
   output logic                    rf_done,
   output logic                    busy
);

   localparam int unsigned DEPTH      = 1 << INDEX_WIDTH;
   localparam int unsigned LINE_BYTES = LINE_WORDS * BEN_WIDTH;

   typedef enum logic {IDLE, REFILL} state_t;
   state_t state, state_nxt;

   logic [LINE_WIDTH-1:0] mem [DEPTH];

   logic                    sb_valid;
   logic [INDEX_WIDTH-1:0]  sb_index;
   logic [OFFSET_WIDTH-1:0] sb_offset;
   logic [WORD_WIDTH-1:0]   sb_data;
   logic [BEN_WIDTH-1:0]    sb_ben;

   logic [INDEX_WIDTH-1:0]  rf_index_q;
   logic [OFFSET_WIDTH-1:0] rf_cnt;
   logic [OFFSET_WIDTH-1:0] rd_off_q;

   logic rf_beat, rf_last, rf_accept, st_accept, rd_accept, drain;

   logic                    wr_en;
   logic [INDEX_WIDTH-1:0]  wr_index;
   logic [OFFSET_WIDTH-1:0] wr_offset;
   logic [WORD_WIDTH-1:0]   wr_word;
   logic [BEN_WIDTH-1:0]    wr_ben;
   logic [LINE_BYTES-1:0]   wr_mask;
   logic [LINE_WIDTH-1:0]   wr_line;
   logic [LINE_WIDTH-1:0]   rd_line_nxt;

   assign rf_beat   = rf_valid && rf_ready;
   assign rf_last   = (rf_cnt == OFFSET_WIDTH'(LINE_WORDS - 1));
   assign rf_accept = rf_start && (state == IDLE) && !busy;
   assign st_accept = st_valid && st_ready;
   assign rd_accept = rd_valid && rd_ready;
   // Refill beats own the array port first; the buffer yields to any accepted read.
   assign drain     = sb_valid && !rd_accept && !rf_beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rf_accept) state_nxt = REFILL;
         REFILL:  if (rf_beat && rf_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rf_ready = 1'b0;
      st_ready = 1'b0;
      rd_ready = 1'b0;
      busy     = 1'b0;
      if (!rst) begin
         rf_ready = (state == REFILL);
         busy     = (state == REFILL) || sb_valid;
         st_ready = (state == IDLE);
         rd_ready = (state == IDLE) && !(sb_valid && st_valid);
`ifndef CACHE_LINE_BANK_FWD_EN
         if (sb_valid && (sb_index == rd_index)) rd_ready = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_index_q    <= '0;
         rf_cnt        <= '0;
         rf_done       <= 1'b0;
         sb_valid      <= 1'b0;
         sb_index      <= '0;
         sb_offset     <= '0;
         sb_data       <= '0;
         sb_ben        <= '0;
         rd_data_valid <= 1'b0;
         rd_line       <= '0;
         rd_off_q      <= '0;
      end else begin
         rf_done       <= rf_beat && rf_last;
         rd_data_valid <= rd_accept;
         if (rf_accept) begin
            rf_index_q <= rf_index;
            rf_cnt     <= '0;
         end else if (rf_beat) begin
            rf_cnt <= rf_cnt + OFFSET_WIDTH'(1);
         end
         if (st_accept) begin
            sb_valid  <= 1'b1;
            sb_index  <= st_index;
            sb_offset <= st_offset;
            sb_data   <= st_data;
            sb_ben    <= st_ben;
         end else if (drain) begin
            sb_valid <= 1'b0;
         end
         if (rd_accept) begin
            rd_line  <= rd_line_nxt;
            rd_off_q <= rd_offset;
         end
      end
   end

   always_comb begin
      wr_en     = 1'b0;
      wr_index  = sb_index;
      wr_offset = sb_offset;
      wr_word   = sb_data;
      wr_ben    = sb_ben;
      if (rf_beat) begin
         wr_en     = 1'b1;
         wr_index  = rf_index_q;
         wr_offset = rf_cnt;
         wr_word   = rf_data;
         wr_ben    = '1;
      end else if (drain) begin
         wr_en = 1'b1;
      end
   end

   always_comb begin
      wr_mask = '0;
      for (int unsigned w = 0; w < LINE_WORDS; w++)
         if (OFFSET_WIDTH'(w) == wr_offset) wr_mask[w*BEN_WIDTH +: BEN_WIDTH] = wr_ben;
      wr_line = {LINE_WORDS{wr_word}};
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int unsigned b = 0; b < LINE_BYTES; b++)
            if (wr_mask[b]) mem[wr_index][b*8 +: 8] <= wr_line[b*8 +: 8];
   end

   always_comb begin
      rd_line_nxt = mem[rd_index];
`ifdef CACHE_LINE_BANK_FWD_EN
      if (sb_valid && (sb_index == rd_index))
         for (int unsigned w = 0; w < LINE_WORDS; w++)
            if (OFFSET_WIDTH'(w) == sb_offset)
               for (int unsigned b = 0; b < BEN_WIDTH; b++)
                  if (sb_ben[b]) rd_line_nxt[w*WORD_WIDTH + b*8 +: 8] = sb_data[b*8 +: 8];
`endif
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned w = 0; w < LINE_WORDS; w++)
         if (OFFSET_WIDTH'(w) == rd_off_q) rd_data = rd_line[w*WORD_WIDTH +: WORD_WIDTH];
   end

endmodule
